dma_engineer_arbiter: RTL and testbench

- Shares one DMA engine between NUM_REQ layer controllers, for example the conv/ip weight-buffer loaders.
- Each layer controller talks to this block with the same req/ack/start_addr/length/dout_en/dout_eop handshake it would use with the DMA engine directly.
- Requests are granted round-robin, one transfer at a time. The winner's address and length are forwarded to the engine, and the returned burst is routed back only to the granted requester.
- Sits between the per-layer controllers and the single DMA engine, outside the layer wrappers.

---
 rtl/dma_engineer_arbiter.sv | 127 ++++++++++++
 tb/tb_dma_engineer_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engineer_arbiter.sv
// rtl/dma_engineer_arbiter.sv - round-robin arbiter sharing one DMA engine among NUM_REQ layer controllers
module dma_engineer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int AW      = 27,
    parameter int DW      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    m_req,
    output logic [NUM_REQ-1:0]    m_ack,
    input  logic [NUM_REQ*AW-1:0] m_start_addr,
    input  logic [NUM_REQ*AW-1:0] m_length,
    output logic [NUM_REQ-1:0]    m_dout_en,
    output logic [NUM_REQ-1:0]    m_dout_eop,
    output logic [DW-1:0]         m_dout,
    output logic                  dma_req,
    input  logic                  dma_ack,
    output logic [AW-1:0]         dma_start_addr,
    output logic [AW-1:0]         dma_length,
    input  logic                  dma_dout_en,
    input  logic                  dma_dout_eop,
    input  logic [DW-1:0]         dma_dout,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  err_len,
    output logic                  err_stray
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB_REQ = 2'd1,
        XFER    = 2'd2
    } state_t;

    localparam logic [AW-1:0]   ONE        = AW'(1);
    localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win;
    logic            found;
    logic [AW-1:0]   beat_cnt;
    logic [AW-1:0]   beat_next;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin : pick_winner
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && m_req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign beat_next = beat_cnt + ONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= LAST_RESET;
            grant_id       <= '0;
            dma_start_addr <= '0;
            dma_length     <= '0;
            beat_cnt       <= '0;
            err_len        <= 1'b0;
            err_stray      <= 1'b0;
        end else begin
            if (dma_dout_en && state != XFER) begin
                err_stray <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id       <= win;
                        dma_start_addr <= m_start_addr[int'(win)*AW +: AW];
                        dma_length     <= m_length[int'(win)*AW +: AW];
                        beat_cnt       <= '0;
                        state          <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (dma_ack) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (dma_dout_en) begin
                        beat_cnt <= beat_next;
                        if (dma_dout_eop) begin
                            if (beat_next != dma_length) begin
                                err_len <= 1'b1;
                            end
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dma_req = (state == ARB_REQ);
    assign busy    = (state != IDLE);
    assign m_dout  = dma_dout;

    // Only the granted layer sees ack and data; everything is held quiet during reset.
    always_comb begin
        m_ack      = '0;
        m_dout_en  = '0;
        m_dout_eop = '0;
        if (rst && state == ARB_REQ && dma_ack) begin
            m_ack[grant_id] = 1'b1;
        end
        if (rst && state == XFER) begin
            m_dout_en[grant_id]  = dma_dout_en;
            m_dout_eop[grant_id] = dma_dout_en & dma_dout_eop;
        end
    end

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// tb/tb_dma_engineer_arbiter.sv - scoreboard bench for dma_engineer_arbiter
module tb_dma_engineer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int AW      = 27;
    localparam int DW      = 512;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    m_req;
    logic [NUM_REQ-1:0]    m_ack;
    logic [NUM_REQ*AW-1:0] m_start_addr;
    logic [NUM_REQ*AW-1:0] m_length;
    logic [NUM_REQ-1:0]    m_dout_en;
    logic [NUM_REQ-1:0]    m_dout_eop;
    logic [DW-1:0]         m_dout;
    logic                  dma_req;
    logic                  dma_ack;
    logic [AW-1:0]         dma_start_addr;
    logic [AW-1:0]         dma_length;
    logic                  dma_dout_en;
    logic                  dma_dout_eop;
    logic [DW-1:0]         dma_dout;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  err_len;
    logic                  err_stray;

    dma_engineer_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_ack(m_ack),
        .m_start_addr(m_start_addr), .m_length(m_length),
        .m_dout_en(m_dout_en), .m_dout_eop(m_dout_eop), .m_dout(m_dout),
        .dma_req(dma_req), .dma_ack(dma_ack),
        .dma_start_addr(dma_start_addr), .dma_length(dma_length),
        .dma_dout_en(dma_dout_en), .dma_dout_eop(dma_dout_eop), .dma_dout(dma_dout),
        .busy(busy), .grant_id(grant_id),
        .err_len(err_len), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        logic        eop;
    } beat_t;

    int    tests = 0;
    int    fails = 0;
    int    grant_q[$];
    beat_t beat_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_layer(input int i, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        m_start_addr[i*AW +: AW] = addr;
        m_length[i*AW +: AW]     = len;
    endtask

    // Monitor: every ack and every routed beat must match the next scoreboard entry.
    int                 mon_e;
    beat_t              mon_b;
    logic [NUM_REQ-1:0] mon_oh;
    always @(negedge clk) begin
        if (m_ack != '0) begin
            if (grant_q.size() == 0) begin
                chk("ack_unexpected", DW'(m_ack), DW'(0));
            end else begin
                mon_e = grant_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e] = 1'b1;
                chk("ack_onehot", DW'(m_ack), DW'(mon_oh));
            end
        end
        if (m_dout_en != '0) begin
            if (beat_q.size() == 0) begin
                chk("beat_unexpected", DW'(m_dout_en), DW'(0));
            end else begin
                mon_b = beat_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_b.id] = 1'b1;
                chk("beat_en", DW'(m_dout_en), DW'(mon_oh));
                chk("beat_eop", DW'(m_dout_eop), mon_b.eop ? DW'(mon_oh) : DW'(0));
                chk("beat_data", m_dout, mon_b.data);
            end
        end else if (m_dout_eop != '0) begin
            chk("eop_without_en", DW'(m_dout_eop), DW'(0));
        end
    end

    task automatic serve(input int id, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                         input int exp_wait, input int nbeats, input bit eop_last);
        int    n;
        beat_t bt;
        n = 0;
        while (!dma_req && n < 10) begin
            tick();
            n++;
        end
        chk("dma_req_rise", DW'(dma_req), DW'(1));
        if (exp_wait >= 0) chk("req_latency", DW'(n), DW'(exp_wait));
        chk("grant_id", DW'(grant_id), DW'(id));
        chk("dma_start_addr", DW'(dma_start_addr), DW'(addr));
        chk("dma_length", DW'(dma_length), DW'(len));
        tick();
        tick();
        chk("addr_stable", DW'(dma_start_addr), DW'(addr));
        dma_ack = 1'b1;
        grant_q.push_back(id);
        tick();
        dma_ack = 1'b0;
        m_req[id] = 1'b0;
        chk("ack_seen", DW'(grant_q.size()), DW'(0));
        chk("dma_req_drop", DW'(dma_req), DW'(0));
        for (int b = 0; b < nbeats; b++) begin
            bt.id   = id;
            bt.data = {16{$urandom}};
            bt.eop  = eop_last && (b == nbeats - 1);
            beat_q.push_back(bt);
            dma_dout_en  = 1'b1;
            dma_dout_eop = bt.eop;
            dma_dout     = bt.data;
            tick();
        end
        dma_dout_en  = 1'b0;
        dma_dout_eop = 1'b0;
        if (eop_last) chk("busy_fall", DW'(busy), DW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m_req = '0;
        m_start_addr = '0;
        m_length = '0;
        dma_ack = 1'b0;
        dma_dout_en = 1'b0;
        dma_dout_eop = 1'b0;
        dma_dout = '0;
        tick();
        tick();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_dma_req", DW'(dma_req), DW'(0));
        chk("rst_grant_id", DW'(grant_id), DW'(0));
        chk("rst_addr", DW'(dma_start_addr), DW'(0));
        chk("rst_len", DW'(dma_length), DW'(0));
        chk("rst_err_len", DW'(err_len), DW'(0));
        chk("rst_err_stray", DW'(err_stray), DW'(0));
        rst = 1'b1;
        tick();

        // Single request on layer 2
        set_layer(2, 1252, 32);
        m_req[2] = 1'b1;
        serve(2, 1252, 32, 1, 32, 1'b1);
        chk("single_err_len", DW'(err_len), DW'(0));

        // Round robin from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_layer(i, AW'(100 * (i + 1)), AW'(4));
        m_req = 4'b1111;
        serve(0, 100, 4, 1, 4, 1'b1);
        serve(1, 200, 4, 1, 4, 1'b1);
        m_req[0] = 1'b1;
        serve(2, 300, 4, 1, 4, 1'b1);
        serve(3, 400, 4, 1, 4, 1'b1);
        serve(0, 100, 4, 1, 4, 1'b1);
        chk("rr_err_len", DW'(err_len), DW'(0));

        // Length mismatch: EOP on beat 31 of 32
        set_layer(1, 5000, 32);
        m_req[1] = 1'b1;
        serve(1, 5000, 32, 1, 31, 1'b1);
        chk("mismatch_err_len", DW'(err_len), DW'(1));
        tick();
        chk("mismatch_sticky", DW'(err_len), DW'(1));
        set_layer(2, 6000, 8);
        m_req[2] = 1'b1;
        serve(2, 6000, 8, 1, 8, 1'b1);
        chk("after_mismatch_err_len", DW'(err_len), DW'(1));
        chk("after_mismatch_stray", DW'(err_stray), DW'(0));

        // Stray beats in IDLE and ARB_REQ
        dma_dout_en = 1'b1;
        dma_dout = {16{$urandom}};
        tick();
        dma_dout_en = 1'b0;
        chk("stray_idle_err", DW'(err_stray), DW'(1));
        chk("stray_idle_busy", DW'(busy), DW'(0));
        set_layer(0, 7000, 6);
        m_req[0] = 1'b1;
        tick();
        chk("stray_arb_enter", DW'(dma_req), DW'(1));
        dma_dout_en = 1'b1;
        tick();
        dma_dout_en = 1'b0;
        chk("stray_arb_state", DW'(dma_req), DW'(1));
        chk("stray_arb_err", DW'(err_stray), DW'(1));
        serve(0, 7000, 6, 0, 6, 1'b1);

        // Reset at beat 10 of a 32-beat burst
        set_layer(2, 8000, 32);
        m_req[2] = 1'b1;
        serve(2, 8000, 32, 1, 10, 1'b0);
        chk("midxfer_busy", DW'(busy), DW'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", DW'(busy), DW'(0));
        chk("midrst_dma_req", DW'(dma_req), DW'(0));
        chk("midrst_dout_en", DW'(m_dout_en), DW'(0));
        chk("midrst_err_len", DW'(err_len), DW'(0));
        chk("midrst_err_stray", DW'(err_stray), DW'(0));
        chk("midrst_grant_id", DW'(grant_id), DW'(0));
        set_layer(0, 9000, 3);
        set_layer(1, 9100, 3);
        m_req = 4'b0011;
        serve(0, 9000, 3, 1, 3, 1'b1);
        serve(1, 9100, 3, 1, 3, 1'b1);

        // Request withdrawn before ack
        set_layer(1, 10000, 5);
        m_req[1] = 1'b1;
        tick();
        chk("withdraw_arb", DW'(dma_req), DW'(1));
        m_req[1] = 1'b0;
        set_layer(1, 123, 77);
        serve(1, 10000, 5, 0, 5, 1'b1);

        tick();
        tick();
        chk("grant_q_empty", DW'(grant_q.size()), DW'(0));
        chk("beat_q_empty", DW'(beat_q.size()), DW'(0));
        chk("final_err_len", DW'(err_len), DW'(0));
        chk("final_err_stray", DW'(err_stray), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
